// File: rtl/ana_probe.sv
// ana_probe: per-cycle signal probe keeping running statistics of a bus.
// Use WIDTH=1 for a digital line; inc/dec counts then become rising/falling edges.
//
// Ports:
//   i_clk      probe clock
//   i_rst      synchronous active-high reset
//   i_clr      synchronous statistics clear (same effect as i_rst)
//   i_din      probed value
//   o_valid    at least one sample captured since reset/clear
//   o_cur      last sampled value
//   o_min      unsigned minimum of samples (all ones when empty)
//   o_max      unsigned maximum of samples (zero when empty)
//   o_chg      one-cycle pulse when the latest sample differs from the previous one
//   o_chg_cnt  number of value changes (saturating)
//   o_inc_cnt  number of increases (saturating)
//   o_dec_cnt  number of decreases (saturating)
//   o_run_len  cycles the current value has been held, current cycle included
//   o_max_run  longest run seen, including the ongoing one
module ana_probe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_din,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_cur,
    output logic [WIDTH-1:0] o_min,
    output logic [WIDTH-1:0] o_max,
    output logic             o_chg,
    output logic [CNT_W-1:0] o_chg_cnt,
    output logic [CNT_W-1:0] o_inc_cnt,
    output logic [CNT_W-1:0] o_dec_cnt,
    output logic [CNT_W-1:0] o_run_len,
    output logic [CNT_W-1:0] o_max_run
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [WIDTH-1:0] VAL_MAX = {WIDTH{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             r_valid;
    logic [WIDTH-1:0] r_cur;
    logic [WIDTH-1:0] r_min;
    logic [WIDTH-1:0] r_max;
    logic             r_chg;
    logic [CNT_W-1:0] r_chg_cnt;
    logic [CNT_W-1:0] r_inc_cnt;
    logic [CNT_W-1:0] r_dec_cnt;
    logic [CNT_W-1:0] r_run_len;
    logic [CNT_W-1:0] r_max_run;

    logic             w_same;
    logic             w_up;
    logic [CNT_W-1:0] w_run_nxt;
    logic [CNT_W-1:0] w_max_run_nxt;

    // Saturating increment shared by every counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // Next run length and longest run; the first sample always starts a run of one.
    always_comb begin
        w_same        = (i_din == r_cur);
        w_up          = (i_din > r_cur);
        w_run_nxt     = CNT_ONE;
        w_max_run_nxt = r_max_run;
        if (r_valid && w_same) begin
            w_run_nxt = sat_inc(r_run_len);
        end
        if (!r_valid) begin
            w_max_run_nxt = CNT_ONE;
        end else if (w_run_nxt > r_max_run) begin
            w_max_run_nxt = w_run_nxt;
        end
    end

    // Statistics registers; reset and clear both discard all history.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_valid   <= 1'b0;
            r_cur     <= '0;
            r_min     <= VAL_MAX;
            r_max     <= '0;
            r_chg     <= 1'b0;
            r_chg_cnt <= '0;
            r_inc_cnt <= '0;
            r_dec_cnt <= '0;
            r_run_len <= '0;
            r_max_run <= '0;
        end else begin
            r_valid   <= 1'b1;
            r_cur     <= i_din;
            r_run_len <= w_run_nxt;
            r_max_run <= w_max_run_nxt;
            if (!r_valid) begin
                r_min <= i_din;
                r_max <= i_din;
                r_chg <= 1'b0;
            end else begin
                if (i_din < r_min) begin
                    r_min <= i_din;
                end
                if (i_din > r_max) begin
                    r_max <= i_din;
                end
                r_chg <= !w_same;
                if (!w_same) begin
                    r_chg_cnt <= sat_inc(r_chg_cnt);
                    if (w_up) begin
                        r_inc_cnt <= sat_inc(r_inc_cnt);
                    end else begin
                        r_dec_cnt <= sat_inc(r_dec_cnt);
                    end
                end
            end
        end
    end

    assign o_valid   = r_valid;
    assign o_cur     = r_cur;
    assign o_min     = r_min;
    assign o_max     = r_max;
    assign o_chg     = r_chg;
    assign o_chg_cnt = r_chg_cnt;
    assign o_inc_cnt = r_inc_cnt;
    assign o_dec_cnt = r_dec_cnt;
    assign o_run_len = r_run_len;
    assign o_max_run = r_max_run;

endmodule

// File: tb/tb_ana_probe.sv
// Bench for ana_probe: three instances (analog 16/16, digital 1/16, saturation 16/4).
// Stimulus pushes hand-computed expectations into a queue; a monitor drains it each negedge.
module tb_ana_probe;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Analog instance
    logic        rst0, clr0;
    logic [15:0] din0;
    logic        v0, chg0;
    logic [15:0] cur0, mn0, mx0, cc0, ic0, dc0, rl0, mr0;

    // Digital instance
    logic        rst1, clr1;
    logic        din1;
    logic        v1, chg1, cur1, mn1, mx1;
    logic [15:0] cc1, ic1, dc1, rl1, mr1;

    // Saturation instance
    logic        rst2, clr2;
    logic [15:0] din2;
    logic        v2, chg2;
    logic [15:0] cur2, mn2, mx2;
    logic [3:0]  cc2, ic2, dc2, rl2, mr2;

    ana_probe #(.WIDTH(16), .CNT_W(16)) u_ana (
        .i_clk(clk), .i_rst(rst0), .i_clr(clr0), .i_din(din0),
        .o_valid(v0), .o_cur(cur0), .o_min(mn0), .o_max(mx0), .o_chg(chg0),
        .o_chg_cnt(cc0), .o_inc_cnt(ic0), .o_dec_cnt(dc0),
        .o_run_len(rl0), .o_max_run(mr0)
    );

    ana_probe #(.WIDTH(1), .CNT_W(16)) u_dig (
        .i_clk(clk), .i_rst(rst1), .i_clr(clr1), .i_din(din1),
        .o_valid(v1), .o_cur(cur1), .o_min(mn1), .o_max(mx1), .o_chg(chg1),
        .o_chg_cnt(cc1), .o_inc_cnt(ic1), .o_dec_cnt(dc1),
        .o_run_len(rl1), .o_max_run(mr1)
    );

    ana_probe #(.WIDTH(16), .CNT_W(4)) u_sat (
        .i_clk(clk), .i_rst(rst2), .i_clr(clr2), .i_din(din2),
        .o_valid(v2), .o_cur(cur2), .o_min(mn2), .o_max(mx2), .o_chg(chg2),
        .o_chg_cnt(cc2), .o_inc_cnt(ic2), .o_dec_cnt(dc2),
        .o_run_len(rl2), .o_max_run(mr2)
    );

    typedef struct {
        int          d;
        int          f;
        logic [15:0] v;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    logic [15:0] sweep     [6] = '{16'd5, 16'd5, 16'd9, 16'd9, 16'd3, 16'd12};
    logic [15:0] sweep_chg [6] = '{16'd0, 16'd0, 16'd1, 16'd0, 16'd1, 16'd1};
    logic [15:0] sweep_run [6] = '{16'd1, 16'd2, 16'd1, 16'd2, 16'd1, 16'd1};
    logic        dig_in    [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [15:0] dig_chg   [7] = '{16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd1, 16'd1};
    logic [15:0] dig_run   [7] = '{16'd1, 16'd2, 16'd1, 16'd2, 16'd3, 16'd1, 16'd1};

    function automatic string fname(input int f);
        case (f)
            0: return "valid";
            1: return "cur";
            2: return "min";
            3: return "max";
            4: return "chg";
            5: return "chg_cnt";
            6: return "inc_cnt";
            7: return "dec_cnt";
            8: return "run_len";
            default: return "max_run";
        endcase
    endfunction

    function automatic logic [15:0] get(input int d, input int f);
        logic [15:0] r;
        r = '0;
        if (d == 0) begin
            case (f)
                0: r = 16'(v0);
                1: r = cur0;
                2: r = mn0;
                3: r = mx0;
                4: r = 16'(chg0);
                5: r = cc0;
                6: r = ic0;
                7: r = dc0;
                8: r = rl0;
                default: r = mr0;
            endcase
        end else if (d == 1) begin
            case (f)
                0: r = 16'(v1);
                1: r = 16'(cur1);
                2: r = 16'(mn1);
                3: r = 16'(mx1);
                4: r = 16'(chg1);
                5: r = cc1;
                6: r = ic1;
                7: r = dc1;
                8: r = rl1;
                default: r = mr1;
            endcase
        end else begin
            case (f)
                0: r = 16'(v2);
                1: r = cur2;
                2: r = mn2;
                3: r = mx2;
                4: r = 16'(chg2);
                5: r = 16'(cc2);
                6: r = 16'(ic2);
                7: r = 16'(dc2);
                8: r = 16'(rl2);
                default: r = 16'(mr2);
            endcase
        end
        return r;
    endfunction

    // Monitor: outputs are stable at negedge; check everything queued since the last edge.
    always @(negedge clk) begin
        exp_t e;
        logic [15:0] act;
        while (q.size() > 0) begin
            e   = q.pop_front();
            act = get(e.d, e.f);
            n_vec++;
            if (act !== e.v) begin
                n_bad++;
                $display("FAIL dut%0d %s: got %h expected %h at %0t", e.d, fname(e.f), act, e.v, $time);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int d, input int f, input logic [15:0] v);
        exp_t e;
        e.d = d;
        e.f = f;
        e.v = v;
        q.push_back(e);
    endtask

    task automatic push_stats(input int d, input logic [15:0] valid, input logic [15:0] cur,
                              input logic [15:0] mn, input logic [15:0] mx, input logic [15:0] chg,
                              input logic [15:0] cc, input logic [15:0] ic, input logic [15:0] dc,
                              input logic [15:0] rl, input logic [15:0] mr);
        push_exp(d, 0, valid);
        push_exp(d, 1, cur);
        push_exp(d, 2, mn);
        push_exp(d, 3, mx);
        push_exp(d, 4, chg);
        push_exp(d, 5, cc);
        push_exp(d, 6, ic);
        push_exp(d, 7, dc);
        push_exp(d, 8, rl);
        push_exp(d, 9, mr);
    endtask

    task automatic push_reset(input int d, input logic [15:0] min_all_ones);
        push_stats(d, 16'd0, 16'd0, min_all_ones, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst0 = 1'b1; clr0 = 1'b0; din0 = '0;
        rst1 = 1'b1; clr1 = 1'b0; din1 = 1'b0;
        rst2 = 1'b1; clr2 = 1'b0; din2 = '0;

        // Reset then hold 5 for four cycles
        tick();
        tick();
        push_reset(0, 16'hFFFF);
        rst0 = 1'b0;
        din0 = 16'h0005;
        repeat (3) begin
            tick();
            push_exp(0, 4, 16'd0);
        end
        tick();
        push_stats(0, 1, 5, 5, 5, 0, 0, 0, 0, 4, 4);

        // Analog sweep from a fresh first capture
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            din0 = sweep[i];
            tick();
            push_exp(0, 4, sweep_chg[i]);
            push_exp(0, 8, sweep_run[i]);
        end
        push_stats(0, 1, 12, 3, 12, 1, 3, 2, 1, 1, 2);

        // Clear mid-run, then resume with 7
        clr0 = 1'b1;
        din0 = 16'd7;
        tick();
        push_reset(0, 16'hFFFF);
        clr0 = 1'b0;
        tick();
        push_stats(0, 1, 7, 7, 7, 0, 0, 0, 0, 1, 1);

        // Reset and clear together with a changing input
        rst0 = 1'b1;
        clr0 = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            din0 = 16'(k);
            tick();
            push_reset(0, 16'hFFFF);
        end

        // Full-scale extremes
        rst0 = 1'b0;
        clr0 = 1'b0;
        din0 = 16'hFFFF;
        tick();
        push_stats(0, 1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 0, 0, 0, 0, 1, 1);
        din0 = 16'h0000;
        tick();
        push_stats(0, 1, 0, 0, 16'hFFFF, 1, 1, 0, 1, 1, 1);

        // Digital probe
        push_reset(1, 16'h0001);
        rst1 = 1'b0;
        for (int i = 0; i < 7; i++) begin
            din1 = dig_in[i];
            tick();
            push_exp(1, 4, dig_chg[i]);
            push_exp(1, 8, dig_run[i]);
            if (i == 1) begin
                push_exp(1, 2, 16'd0);
                push_exp(1, 3, 16'd0);
            end
        end
        push_stats(1, 1, 1, 0, 1, 1, 3, 2, 1, 1, 3);

        // Saturation with 4-bit counters
        push_reset(2, 16'hFFFF);
        rst2 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            din2 = 16'(i % 2);
            tick();
            if (i == 14) begin
                push_exp(2, 5, 16'd14);
                push_exp(2, 6, 16'd7);
                push_exp(2, 7, 16'd7);
            end
        end
        push_stats(2, 1, 1, 0, 1, 1, 15, 15, 15, 1, 1);
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 13) begin
                push_exp(2, 8, 16'd14);
                push_exp(2, 9, 16'd14);
            end
        end
        push_stats(2, 1, 1, 0, 1, 0, 15, 15, 15, 15, 15);

        // Let the monitor drain, then confirm nothing was left unchecked
        tick();
        @(negedge clk);
        #1;
        n_vec++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: got %0d pending expected 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ana_probe.md
Name: ana_probe

Overview:
- Generic on-chip/bench signal probe for observing analog-code buses (e.g. an 8-bit power-current code zero-extended to 16 bits) and single-bit digital status lines (sleep, oscillator-low, power-enable, discharge).
- Samples its input every clock and keeps running statistics readable by the bench or a debug bus: current value, min/max, change, increase and decrease counts, and stable-run lengths.
- The digital-probe variant is this block with WIDTH=1; for it, increase/decrease counts are rising/falling-edge counts.

Parameters:
- WIDTH, 16, probed bus width (1 for digital probe).
- CNT_W, 16, width of all event and run-length counters.

Ports:
- i_clk  input  1  probe clock.
- i_rst  input  1  synchronous active-high reset.
- i_clr  input  1  synchronous statistics clear; same effect as i_rst.
- i_din  input  WIDTH  probed value.
- o_valid  output  1  at least one sample captured since reset/clear.
- o_cur  output  WIDTH  last sampled value.
- o_min  output  WIDTH  minimum sampled value, unsigned.
- o_max  output  WIDTH  maximum sampled value, unsigned.
- o_chg  output  1  one-cycle pulse: the latest sample differs from the previous one.
- o_chg_cnt  output  CNT_W  number of value changes.
- o_inc_cnt  output  CNT_W  number of increases (rising edges when WIDTH=1).
- o_dec_cnt  output  CNT_W  number of decreases (falling edges when WIDTH=1).
- o_run_len  output  CNT_W  cycles the current value has been held, including the current cycle.
- o_max_run  output  CNT_W  longest completed or ongoing run.

Behaviour:
- All state updates on posedge i_clk. i_rst has priority over i_clr; i_clr has priority over sampling.
- Reset/clear values:
  - o_valid=0, o_cur=0, o_min=all ones, o_max=0, o_chg=0.
  - All counters = 0, o_run_len=0, o_max_run=0.
- The cycle with i_rst or i_clr asserted captures no sample. Sampling resumes the first cycle after deassertion.
- First sample (o_valid=0, no reset/clear):
  - o_cur=o_min=o_max=i_din, o_valid=1.
  - o_run_len=1, o_max_run=1, o_chg=0, counters unchanged.
- Subsequent samples, o_valid=1, i_din==o_cur:
  - o_run_len increments, saturating at 2^CNT_W-1.
  - o_chg=0.
- Subsequent samples, o_valid=1, i_din!=o_cur:
  - o_cur=i_din, o_chg=1 for exactly this update.
  - o_chg_cnt increments.
  - o_inc_cnt increments if i_din>o_cur (unsigned compare), else o_dec_cnt increments.
  - o_run_len=1.
- o_min/o_max update on every sample with unsigned compare. Equal values leave them unchanged.
- o_max_run is updated whenever the next o_run_len exceeds it, so it tracks an ongoing run. Whenever o_valid=1, o_max_run >= o_run_len.
- Every counter saturates at all ones and never wraps. Saturation of one counter does not affect the others.
- Latency: outputs reflect i_din one clock after the sampling edge. All outputs are registered, with no combinational path from i_din.
- WIDTH=1:
  - o_min/o_max report whether a 0 / a 1 has ever been seen.
  - o_inc_cnt+o_dec_cnt == o_chg_cnt when no counter is saturated.
- Reset or clear mid-run discards all history. The next sample is treated as a first sample.
- X on i_din is not filtered; the implementation must be synthesizable RTL with no simulation-only constructs.

Test Plan:
- Reset: i_rst=1 for 2 cycles, then i_din=16'h0005 held 4 cycles -> o_valid=1, o_cur=5, o_min=o_max=5, o_run_len=4, o_max_run=4, all counts 0, o_chg never high.
- Analog sweep: samples 5,9,9,3,12 after first capture -> o_chg_cnt=3, o_inc_cnt=2, o_dec_cnt=1, o_min=3, o_max=12, o_run_len=1, o_max_run=2.
- Digital probe (WIDTH=1): i_din 0,0,1,1,1,0,1 -> o_inc_cnt=2, o_dec_cnt=1, o_max_run=3, o_min=0, o_max=1, o_chg pulses exactly 3 single cycles.
- Saturation with CNT_W=4: toggle i_din every cycle for 40 cycles -> o_chg_cnt=15, o_inc_cnt=15, o_dec_cnt=15, no wrap. Constant input 30 cycles -> o_run_len=15, o_max_run=15.
- Clear mid-run: after the sweep scenario, pulse i_clr one cycle while i_din=7 -> next cycle all stats at reset values. One cycle later o_valid=1, o_cur=7, o_min=o_max=7.
- Priority: assert i_rst and i_clr together with changing i_din -> state held at reset values, no counter increments.
